// File: rtl/game_flow_ctrl.sv
// Screen sequencer: menu/record/countdown/play FSM, button edge detect, circular volume
// record buffer and tick-divided start countdown. Optional menu timeout via MENU_TIMEOUT_EN.
module game_flow_ctrl #(
    parameter int unsigned VOL_W         = 5,
    parameter int unsigned REC_DEPTH     = 16,
    parameter int unsigned VOL_THRESH    = 3,
    parameter int unsigned TICK_DIV      = 100000000,
    parameter int unsigned COUNT_FROM    = 5,
    parameter int unsigned TIMEOUT_TICKS = 30,
    localparam int unsigned AW = $clog2(REC_DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sw,
    input  logic             btnL,
    input  logic             btnR,
    input  logic             btnC,
    input  logic [VOL_W-1:0] volume,
    input  logic             sample_stb,
    input  logic [AW-1:0]    rec_rd_addr,
    output logic [VOL_W-1:0] rec_rd_data,
    output logic [CW-1:0]    rec_count,
    output logic [3:0]       screen,
    output logic [3:0]       countdown,
    output logic             play_start
);

    localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StTitle     = 4'd1,
        StControls1 = 4'd2,
        StControls2 = 4'd3,
        StSettings  = 4'd4,
        StMicCheck  = 4'd5,
        StRecordArm = 4'd6,
        StRecord    = 4'd7,
        StCountdown = 4'd8,
        StPlay      = 4'd9
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           btn_q, rise_q, rise_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        rec_count_q, rec_count_d, rec_count_wr;
    logic [3:0]           countdown_q, countdown_d;
    logic [DW-1:0]        div_q, div_d;
    logic                 play_start_q, play_start_d;
    logic                 counting, tick, do_write, entering_arm;
    logic                 rise_l, rise_r, rise_c;
    logic [VOL_W-1:0]     mem [REC_DEPTH];
    logic [AW-1:0]        rd_idx;

`ifdef MENU_TIMEOUT_EN
    localparam int unsigned IW = $clog2(TIMEOUT_TICKS + 1);
    logic [IW-1:0] idle_q, idle_d;
    logic          in_menu;

    assign in_menu = (state_q == StControls1) || (state_q == StControls2) ||
                     (state_q == StSettings) || (state_q == StMicCheck);
    assign counting = (state_q == StCountdown) || in_menu;
`else
    assign counting = (state_q == StCountdown);
`endif

    // Bit order of button vectors: 0 = L, 1 = R, 2 = C.
    assign rise_d = {btnC, btnR, btnL} & ~btn_q;
    assign rise_l = rise_q[0];
    assign rise_r = rise_q[1];
    assign rise_c = rise_q[2];

    assign tick     = counting && (div_q == DW'(TICK_DIV - 1));
    assign do_write = (state_q == StRecord) && sample_stb;
    assign rec_count_wr = (do_write && rec_count_q != CW'(REC_DEPTH)) ? rec_count_q + 1'b1
                                                                      : rec_count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:      if (sw) state_d = StTitle;
            StTitle:     if (rise_r) state_d = StControls1;
            StControls1: begin
                if (rise_r)      state_d = StControls2;
                else if (rise_l) state_d = StTitle;
            end
            StControls2: begin
                if (rise_r)      state_d = StSettings;
                else if (rise_l) state_d = StControls1;
            end
            StSettings: begin
                if (rise_r)      state_d = StMicCheck;
                else if (rise_l) state_d = StControls2;
            end
            StMicCheck:  if (int'(volume) > int'(VOL_THRESH)) state_d = StRecordArm;
            StRecordArm: if (btnC) state_d = StRecord;
            StRecord: begin
                if (!btnC || rec_count_wr == CW'(REC_DEPTH)) state_d = StCountdown;
            end
            StCountdown: if (tick && countdown_q == 4'd0) state_d = StPlay;
            StPlay:      if (rise_c) state_d = StRecordArm;
            default:     state_d = StIdle;
        endcase
`ifdef MENU_TIMEOUT_EN
        if (in_menu && state_d == state_q && rise_q == 3'b000 && tick &&
            idle_q == IW'(TIMEOUT_TICKS - 1)) begin
            state_d = StTitle;
        end
`endif
        if (!sw) state_d = StIdle;
    end

    assign entering_arm = (state_d == StRecordArm) && (state_q != StRecordArm);
    assign play_start_d = (state_q == StCountdown) && (state_d == StPlay);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rec_count_d = rec_count_wr;
        if (entering_arm) begin
            wr_ptr_d    = '0;
            rec_count_d = '0;
        end else if (do_write) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        countdown_d = countdown_q;
        if (state_d == StCountdown && state_q != StCountdown) begin
            countdown_d = 4'(COUNT_FROM);
        end else if (state_q == StCountdown && tick && countdown_q != 4'd0) begin
            countdown_d = countdown_q - 4'd1;
        end

        // Divider restarts on every state change so each screen sees full ticks.
        if (state_d != state_q || !counting || tick) div_d = '0;
        else                                          div_d = div_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            btn_q        <= '0;
            rise_q       <= '0;
            wr_ptr_q     <= '0;
            rec_count_q  <= '0;
            countdown_q  <= 4'(COUNT_FROM);
            div_q        <= '0;
            play_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_q        <= {btnC, btnR, btnL};
            rise_q       <= rise_d;
            wr_ptr_q     <= wr_ptr_d;
            rec_count_q  <= rec_count_d;
            countdown_q  <= countdown_d;
            div_q        <= div_d;
            play_start_q <= play_start_d;
        end
    end

`ifdef MENU_TIMEOUT_EN
    always_comb begin
        if (state_d != state_q || rise_q != 3'b000) idle_d = '0;
        else if (in_menu && tick)                   idle_d = idle_q + 1'b1;
        else                                        idle_d = idle_q;
    end

    always_ff @(posedge clk) begin
        if (reset) idle_q <= '0;
        else       idle_q <= idle_d;
    end
`endif

    // Buffer contents deliberately survive reset; rec_count gates what is visible.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr_q] <= volume;
    end

    assign rd_idx      = wr_ptr_q - AW'(1) - rec_rd_addr;
    assign rec_rd_data = ({1'b0, rec_rd_addr} < rec_count_q) ? mem[rd_idx] : '0;

    assign rec_count  = rec_count_q;
    assign screen     = state_q;
    assign countdown  = countdown_q;
    assign play_start = play_start_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: navigation, mic gate, record buffer, countdown, abort.
module tb_game_flow_ctrl;

    localparam int unsigned VOL_W      = 5;
    localparam int unsigned REC_DEPTH  = 16;
    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned COUNT_FROM = 2;

    logic       clk = 1'b0;
    logic       reset, sw, btnL, btnR, btnC, sample_stb;
    logic [4:0] volume;
    logic [3:0] rec_rd_addr;
    logic [4:0] rec_rd_data;
    logic [4:0] rec_count;
    logic [3:0] screen;
    logic [3:0] countdown;
    logic       play_start;

    int n_checks = 0;
    int n_fail   = 0;

    game_flow_ctrl #(
        .VOL_W        (VOL_W),
        .REC_DEPTH    (REC_DEPTH),
        .VOL_THRESH   (3),
        .TICK_DIV     (TICK_DIV),
        .COUNT_FROM   (COUNT_FROM),
        .TIMEOUT_TICKS(30)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw         (sw),
        .btnL       (btnL),
        .btnR       (btnR),
        .btnC       (btnC),
        .volume     (volume),
        .sample_stb (sample_stb),
        .rec_rd_addr(rec_rd_addr),
        .rec_rd_data(rec_rd_data),
        .rec_count  (rec_count),
        .screen     (screen),
        .countdown  (countdown),
        .play_start (play_start)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        cyc(3);
        n_checks++; if (screen !== 4'd0) begin n_fail++; $display("FAIL reset_screen: got %0d want 0", screen); end
        n_checks++; if (rec_count !== 5'd0) begin n_fail++; $display("FAIL reset_rec_count: got %0d want 0", rec_count); end
        n_checks++; if (countdown !== 4'd2) begin n_fail++; $display("FAIL reset_countdown: got %0d want 2", countdown); end
        n_checks++; if (play_start !== 1'b0) begin n_fail++; $display("FAIL reset_play_start: got %0b want 0", play_start); end
        n_checks++; if (rec_rd_data !== 5'd0) begin n_fail++; $display("FAIL reset_rd_data: got %0d want 0", rec_rd_data); end
        reset = 1'b0;
        cyc(1);
        n_checks++; if (screen !== 4'd1) begin n_fail++; $display("FAIL release_title: got %0d want 1", screen); end
    endtask

    task automatic test_navigation();
        logic [5:0] is_right;
        int         exp_screen [6];
        is_right   = 6'b111011;  // bit k: pulse k is R (else L)
        exp_screen = '{2, 3, 2, 3, 4, 5};
        btnR = 1'b1;
        cyc(1);
        n_checks++; if (screen !== 4'd1) begin n_fail++; $display("FAIL edge_latency: got %0d want 1", screen); end
        cyc(1);
        n_checks++; if (screen !== 4'd2) begin n_fail++; $display("FAIL first_advance: got %0d want 2", screen); end
        cyc(48);
        n_checks++; if (screen !== 4'd2) begin n_fail++; $display("FAIL held_no_repeat: got %0d want 2", screen); end
        btnR = 1'b0;
        cyc(1);
        btnL = 1'b1;
        cyc(2);
        n_checks++; if (screen !== 4'd1) begin n_fail++; $display("FAIL back_to_title: got %0d want 1", screen); end
        btnL = 1'b0;
        cyc(1);
        btnL = 1'b1;
        cyc(3);
        n_checks++; if (screen !== 4'd1) begin n_fail++; $display("FAIL back_on_title: got %0d want 1", screen); end
        btnL = 1'b0;
        cyc(1);
        for (int k = 0; k < 6; k++) begin
            if (is_right[k]) btnR = 1'b1;
            else             btnL = 1'b1;
            cyc(2);
            n_checks++;
            if (screen !== 4'(exp_screen[k])) begin
                n_fail++;
                $display("FAIL nav_step%0d: got %0d want %0d", k, screen, exp_screen[k]);
            end
            btnR = 1'b0;
            btnL = 1'b0;
            cyc(1);
        end
    endtask

    task automatic test_mic_check();
        volume = 5'd3;
        cyc(100);
        n_checks++; if (screen !== 4'd5) begin n_fail++; $display("FAIL mic_at_thresh: got %0d want 5", screen); end
        volume = 5'd4;
        cyc(1);
        n_checks++; if (screen !== 4'd6) begin n_fail++; $display("FAIL mic_above_thresh: got %0d want 6", screen); end
        volume = 5'd0;
    endtask

    task automatic test_record_full();
        int waited;
        btnC = 1'b1;
        cyc(1);
        n_checks++; if (screen !== 4'd7) begin n_fail++; $display("FAIL enter_record: got %0d want 7", screen); end
        n_checks++; if (rec_count !== 5'd0) begin n_fail++; $display("FAIL record_count0: got %0d want 0", rec_count); end
        for (int i = 0; i < 20; i++) begin
            volume     = 5'(i);
            sample_stb = 1'b1;
            cyc(1);
            if (i == 14) begin
                n_checks++; if (screen !== 4'd7) begin n_fail++; $display("FAIL record_15th: got %0d want 7", screen); end
                n_checks++; if (rec_count !== 5'd15) begin n_fail++; $display("FAIL count_15th: got %0d want 15", rec_count); end
            end
            if (i == 15) begin
                n_checks++; if (screen !== 4'd8) begin n_fail++; $display("FAIL full_exit: got %0d want 8", screen); end
                n_checks++; if (rec_count !== 5'd16) begin n_fail++; $display("FAIL count_full: got %0d want 16", rec_count); end
            end
        end
        sample_stb = 1'b0;
        n_checks++; if (rec_count !== 5'd16) begin n_fail++; $display("FAIL count_saturate: got %0d want 16", rec_count); end
        n_checks++; if (countdown !== 4'd1) begin n_fail++; $display("FAIL first_tick: got %0d want 1", countdown); end
        rec_rd_addr = 4'd0;
        #1;
        n_checks++; if (rec_rd_data !== 5'd15) begin n_fail++; $display("FAIL rd_newest: got %0d want 15", rec_rd_data); end
        rec_rd_addr = 4'd15;
        #1;
        n_checks++; if (rec_rd_data !== 5'd0) begin n_fail++; $display("FAIL rd_oldest: got %0d want 0", rec_rd_data); end
        rec_rd_addr = 4'd7;
        #1;
        n_checks++; if (rec_rd_data !== 5'd8) begin n_fail++; $display("FAIL rd_mid: got %0d want 8", rec_rd_data); end
        waited = 0;
        while (waited < 20 && screen !== 4'd9) begin
            cyc(1);
            waited++;
        end
        n_checks++; if (waited != 8) begin n_fail++; $display("FAIL play_latency: got %0d cycles want 8", waited); end
        n_checks++; if (play_start !== 1'b1) begin n_fail++; $display("FAIL play_pulse: got %0b want 1", play_start); end
        btnC = 1'b0;
        cyc(2);
        n_checks++; if (screen !== 4'd9) begin n_fail++; $display("FAIL play_hold: got %0d want 9", screen); end
        n_checks++; if (play_start !== 1'b0) begin n_fail++; $display("FAIL pulse_width: got %0b want 0", play_start); end
    endtask

    task automatic test_countdown();
        btnC = 1'b1;
        cyc(2);
        n_checks++; if (screen !== 4'd6) begin n_fail++; $display("FAIL replay_arm: got %0d want 6", screen); end
        n_checks++; if (rec_count !== 5'd0) begin n_fail++; $display("FAIL replay_clear: got %0d want 0", rec_count); end
        cyc(1);
        n_checks++; if (screen !== 4'd7) begin n_fail++; $display("FAIL replay_record: got %0d want 7", screen); end
        sample_stb = 1'b1;
        for (int v = 9; v < 12; v++) begin
            volume = 5'(v);
            cyc(1);
        end
        volume = 5'd12;
        btnC   = 1'b0;
        cyc(1);
        sample_stb = 1'b0;
        n_checks++; if (screen !== 4'd8) begin n_fail++; $display("FAIL release_exit: got %0d want 8", screen); end
        n_checks++; if (rec_count !== 5'd4) begin n_fail++; $display("FAIL exit_strobe_count: got %0d want 4", rec_count); end
        n_checks++; if (countdown !== 4'd2) begin n_fail++; $display("FAIL cd_load: got %0d want 2", countdown); end
        rec_rd_addr = 4'd0;
        #1;
        n_checks++; if (rec_rd_data !== 5'd12) begin n_fail++; $display("FAIL rd_exit_sample: got %0d want 12", rec_rd_data); end
        rec_rd_addr = 4'd3;
        #1;
        n_checks++; if (rec_rd_data !== 5'd9) begin n_fail++; $display("FAIL rd_first_sample: got %0d want 9", rec_rd_data); end
        rec_rd_addr = 4'd4;
        #1;
        n_checks++; if (rec_rd_data !== 5'd0) begin n_fail++; $display("FAIL rd_beyond_count: got %0d want 0", rec_rd_data); end
        for (int k = 1; k <= 13; k++) begin
            cyc(1);
            if (k == 3) begin
                n_checks++; if (countdown !== 4'd2) begin n_fail++; $display("FAIL cd_k3: got %0d want 2", countdown); end
            end
            if (k == 4) begin
                n_checks++; if (countdown !== 4'd1) begin n_fail++; $display("FAIL cd_k4: got %0d want 1", countdown); end
            end
            if (k == 8) begin
                n_checks++; if (countdown !== 4'd0) begin n_fail++; $display("FAIL cd_k8: got %0d want 0", countdown); end
            end
            if (k == 11) begin
                n_checks++; if (screen !== 4'd8) begin n_fail++; $display("FAIL cd_k11_screen: got %0d want 8", screen); end
                n_checks++; if (play_start !== 1'b0) begin n_fail++; $display("FAIL cd_k11_pulse: got %0b want 0", play_start); end
            end
            if (k == 12) begin
                n_checks++; if (screen !== 4'd9) begin n_fail++; $display("FAIL cd_k12_screen: got %0d want 9", screen); end
                n_checks++; if (play_start !== 1'b1) begin n_fail++; $display("FAIL cd_k12_pulse: got %0b want 1", play_start); end
            end
            if (k == 13) begin
                n_checks++; if (play_start !== 1'b0) begin n_fail++; $display("FAIL cd_k13_pulse: got %0b want 0", play_start); end
            end
        end
    endtask

    task automatic test_sw_abort();
        btnC = 1'b1;
        cyc(3);
        btnC = 1'b0;
        cyc(1);
        n_checks++; if (screen !== 4'd8) begin n_fail++; $display("FAIL abort_enter_cd: got %0d want 8", screen); end
        cyc(5);
        n_checks++; if (countdown !== 4'd1) begin n_fail++; $display("FAIL abort_mid_count: got %0d want 1", countdown); end
        sw = 1'b0;
        cyc(1);
        n_checks++; if (screen !== 4'd0) begin n_fail++; $display("FAIL sw_low_idle: got %0d want 0", screen); end
        n_checks++; if (countdown !== 4'd1) begin n_fail++; $display("FAIL sw_low_keep_cd: got %0d want 1", countdown); end
        cyc(3);
        n_checks++; if (screen !== 4'd0) begin n_fail++; $display("FAIL idle_hold: got %0d want 0", screen); end
        sw = 1'b1;
        cyc(1);
        n_checks++; if (screen !== 4'd1) begin n_fail++; $display("FAIL sw_high_title: got %0d want 1", screen); end
    endtask

    initial begin
        reset       = 1'b1;
        sw          = 1'b1;
        btnL        = 1'b0;
        btnR        = 1'b0;
        btnC        = 1'b0;
        sample_stb  = 1'b0;
        volume      = 5'd0;
        rec_rd_addr = 4'd0;
        test_reset();
        test_navigation();
        test_mic_check();
        test_record_full();
        test_countdown();
        test_sw_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1);
    end

endmodule
